// File: rtl/srff_bank_arbiter.sv
// Bank of NFLAG SR flag bits shared by NREQ requesters through a round-robin
// arbiter; each grant performs one set/reset and returns the flag's prior value.
module srff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic                 rd_q,
  output logic                 err,
  output logic [NFLAG-1:0]     q,
  output logic [NFLAG-1:0]     qbar
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    ptr_nxt;
  logic [NREQ-1:0]  elig;
  logic             found;
  logic [IDXW-1:0]  win_idx;
  logic             in_range;
  logic             cur_q;
  logic [NFLAG-1:0] upd;

  // A requester granted on the previous edge is masked so a held req is not re-granted.
  assign elig = req & ~gnt;

  // NOTE: every variable written in always_comb gets a default first, so no path
  // through the loop can leave it unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign win_idx  = idx[int'(win)*IDXW +: IDXW];
  assign in_range = int'(win_idx) < NFLAG;
  assign ptr_nxt  = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

  // One-hot update mask; empty for no grant or an out-of-range index.
  always_comb begin
    upd   = '0;
    cur_q = 1'b0;
    for (int k = 0; k < NFLAG; k++) begin
      upd[k] = found && in_range && (int'(win_idx) == k);
      cur_q  = cur_q | (upd[k] & q[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; rd_q therefore captures q before its own update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt  <= '0;
      rd_q <= 1'b0;
      err  <= 1'b0;
      q    <= '0;
      qbar <= '1;
      ptr  <= '0;
    end else begin
      gnt  <= found ? (NREQ'(1) << win) : '0;
      rd_q <= found & cur_q;
      err  <= found & ~in_range;
      q    <= (q    & ~upd) | (upd & {NFLAG{ op[win]}});
      qbar <= (qbar & ~upd) | (upd & {NFLAG{~op[win]}});
      if (found) ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Directed bench for srff_bank_arbiter: a behavioural model queues expected
// outputs each cycle; directed constant checks cover the listed scenarios.
module tb_srff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IDXW  = 3;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic             rd_q;
    logic             err;
    logic [NFLAG-1:0] q;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, op;
  logic [NREQ*IDXW-1:0] idx;
  logic [NREQ-1:0]      gnt;
  logic                 rd_q, err;
  logic [NFLAG-1:0]     q, qbar;

  logic [NREQ-1:0]      req6, op6;
  logic [NREQ*IDXW-1:0] idx6;
  logic [NREQ-1:0]      gnt6;
  logic                 rd_q6, err6;
  logic [5:0]           q6, qbar6;

  int tests = 0;
  int fails = 0;

  exp_t            sb[$];
  logic [NFLAG-1:0] mq;
  logic [1:0]       mptr;
  logic [NREQ-1:0]  mgnt;

  srff_bank_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .rd_q(rd_q), .err(err), .q(q), .qbar(qbar)
  );

  srff_bank_arbiter #(.NREQ(NREQ), .NFLAG(6), .IDXW(IDXW)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .op(op6), .idx(idx6),
    .gnt(gnt6), .rd_q(rd_q6), .err(err6), .q(q6), .qbar(qbar6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Behavioural reference: round-robin scan from mptr over req & ~last grant.
  task automatic model_step(output exp_t e);
    logic [NREQ-1:0] elig;
    logic [IDXW-1:0] ix;
    int w;
    e = '0;
    if (rst) begin
      mq = '0; mptr = '0; mgnt = '0;
    end else begin
      elig = req & ~mgnt;
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && elig[(int'(mptr) + k) % NREQ]) w = (int'(mptr) + k) % NREQ;
      if (w >= 0) begin
        ix = idx[w*IDXW +: IDXW];
        e.gnt = NREQ'(1) << w;
        if (int'(ix) < NFLAG) begin
          e.rd_q = mq[ix];
          mq[ix] = op[w];
        end else begin
          e.err = 1'b1;
        end
        mptr = 2'((w + 1) % NREQ);
        mgnt = e.gnt;
      end else begin
        mgnt = '0;
      end
    end
    e.q = mq;
  endtask

  task automatic cycle();
    exp_t e;
    logic [NFLAG-1:0] nq;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    nq = ~e.q;
    check("sb_gnt",  32'(gnt),  32'(e.gnt));
    check("sb_rd_q", 32'(rd_q), 32'(e.rd_q));
    check("sb_err",  32'(err),  32'(e.err));
    check("sb_q",    32'(q),    32'(e.q));
    check("sb_qbar", 32'(qbar), 32'(nq));
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; idx = '0;
    req6 = '0; op6 = '0; idx6 = '0;
    mq = '0; mptr = '0; mgnt = '0;
    cycle();
    cycle();
    check("rst_gnt",  32'(gnt),  32'h0);
    check("rst_qbar", 32'(qbar), 32'hFF);
    rst = 1'b0;

    // Single set then reset of flag 3 by requester 0.
    req = 4'b0001; op = 4'b0001; idx = 12'd3;
    cycle();
    check("set_gnt",  32'(gnt),  32'h1);
    check("set_rd_q", 32'(rd_q), 32'h0);
    check("set_q",    32'(q),    32'h08);
    op = 4'b0000;
    cycle();
    check("mask_gnt", 32'(gnt), 32'h0);
    cycle();
    check("clr_gnt",  32'(gnt),  32'h1);
    check("clr_rd_q", 32'(rd_q), 32'h1);
    check("clr_q",    32'(q),    32'h00);
    check("clr_qbar", 32'(qbar), 32'hFF);
    req = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Round robin: four requesters, distinct flags 0..3.
    req = 4'b1111; op = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1) << (k % 4));
      if (k == 3) check("rr_q", 32'(q), 32'h0F);
    end

    // Test-and-set contention on flag 5 with ptr at 1.
    req = 4'b0110; op = 4'b0110; idx = {3'd0, 3'd5, 3'd5, 3'd0};
    cycle();
    check("ts1_gnt",  32'(gnt),  32'h2);
    check("ts1_rd_q", 32'(rd_q), 32'h0);
    req = 4'b0100;
    cycle();
    check("ts2_gnt",  32'(gnt),  32'h4);
    check("ts2_rd_q", 32'(rd_q), 32'h1);
    check("ts_q5",    32'(q[5]), 32'h1);

    // Reset right after the grant to requester 2, with everyone requesting.
    req = 4'b1111; op = 4'b0000; idx = '0;
    rst = 1'b1;
    #1;
    check("rc_gnt", 32'(gnt), 32'h0);
    check("rc_q",   32'(q),   32'h00);
    cycle();
    rst = 1'b0;
    cycle();
    check("rc_first_gnt", 32'(gnt), 32'h1);

    // Build q = A5, then assert rst mid-cycle and observe without a clock edge.
    op = 4'b1111; idx = {3'd7, 3'd2, 3'd5, 3'd0};
    for (int k = 0; k < 4; k++) cycle();
    check("a5_q", 32'(q), 32'hA5);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("amid_q",    32'(q),    32'h00);
    check("amid_qbar", 32'(qbar), 32'hFF);
    check("amid_gnt",  32'(gnt),  32'h0);
    check("amid_rd_q", 32'(rd_q), 32'h0);
    cycle();
    rst = 1'b0;

    // Out-of-range indices on the NFLAG=6 instance; 6 is the first invalid index.
    req6 = 4'b0001; op6 = 4'b0001; idx6 = 12'd7;
    cycle();
    check("oor7_gnt",  32'(gnt6),  32'h1);
    check("oor7_err",  32'(err6),  32'h1);
    check("oor7_rd_q", 32'(rd_q6), 32'h0);
    check("oor7_q",    32'(q6),    32'h00);
    req6 = '0;
    cycle();
    check("oor_idle_err", 32'(err6), 32'h0);
    req6 = 4'b0001; idx6 = 12'd6;
    cycle();
    check("oor6_err", 32'(err6), 32'h1);
    check("oor6_q",   32'(q6),   32'h00);
    req6 = '0;
    cycle();
    req6 = 4'b0001; idx6 = 12'd5;
    cycle();
    check("in5_err",  32'(err6),  32'h0);
    check("in5_q",    32'(q6),    32'h20);
    check("in5_qbar", 32'(qbar6), 32'h1F);
    req6 = '0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/srff_bank_arbiter.md
# srff_bank_arbiter

Shared bank of NFLAG set/reset flag bits, each with SR flip-flop semantics (q/qbar pair, set or reset on a clock edge, hold otherwise). Up to NREQ requesters share the bank through a round-robin arbiter that grants one operation per cycle. Each grant returns the flag's previous value, so requesters can use the bank as test-and-set semaphores. The block sits between requester control logic and any consumer of the flag outputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of flag bits
- IDXW, 3, flag index width; NFLAG <= 2**IDXW

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  per-requester operation request, level; held until granted
- op  in  NREQ  per-requester opcode: 1 = set flag, 0 = reset flag
- idx  in  NREQ*IDXW  packed flag indices; requester i uses [i*IDXW +: IDXW]
- gnt  out  NREQ  registered one-hot grant, one-cycle pulse
- rd_q  out  1  flag value before the granted operation; valid while gnt != 0
- err  out  1  one-cycle pulse with gnt when the granted idx >= NFLAG
- q  out  NFLAG  flag state
- qbar  out  NFLAG  complement of q, registered alongside q

## Operation
- Reset (async, rst=1) forces q=0, qbar=all ones, gnt=0, rd_q=0, err=0, and round-robin pointer ptr=0. All of these hold while rst=1.
- Eligible set: req[i]=1 AND gnt[i]=0. A requester granted this cycle is masked, so a held req is not double-granted.
- Winner w: the first eligible index scanning ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
- On each rising edge with at least one eligible requester:
  - gnt <= onehot(w)
  - rd_q <= q[idx_w] (pre-update value)
  - q[idx_w] <= op[w] and qbar[idx_w] <= ~op[w], only if idx_w < NFLAG
  - err <= (idx_w >= NFLAG); an out-of-range op is granted but changes no flag, and rd_q <= 0
  - ptr <= (w+1) mod NREQ
- On each rising edge with no eligible requester: gnt=0, rd_q=0, err=0. Flags and ptr hold.
- Flags not addressed by a grant always hold. q[k] == ~qbar[k] at all times outside reset.
- Requester protocol: keep req, op and idx stable until gnt[i] is seen high, then drop req or change op/idx for the next cycle. If req is still high in the cycle after the grant, it is a new request.
- Conflicts: simultaneous requests to the same flag are serialized in round-robin order. The later grant's op determines the final value, and each grant's rd_q reflects the earlier grant's result.
- Set-then-reset ordering within one cycle is impossible; exactly one operation per edge.

## Timing
- Latency: req sampled at edge N; gnt/rd_q/err valid and q/qbar updated after edge N (visible in cycle N+1).
- Throughput: one operation per cycle across the bank. A single requester holding req continuously gets a grant every 2nd cycle because of the grant mask.
- Fairness: with all NREQ requesters continuously requesting, each is granted exactly once per NREQ grants.
- rst asserted mid-operation: the in-flight grant is lost (gnt cleared, no flag update if rst is already high at the edge). Pending reqs re-arbitrate from ptr=0 on the first edge after rst deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset values: assert rst mid-cycle with q=8'hA5. Required: q=8'h00, qbar=8'hFF, gnt=0, rd_q=0 immediately, with no clock edge needed.
- Single set/reset: req0=1, op0=1, idx0=3 for 1 cycle. Required: next cycle gnt=4'b0001, rd_q=0, q=8'h08. Then op0=0, idx0=3. Required: gnt=4'b0001, rd_q=1, q=8'h00, qbar=8'hFF.
- Round-robin: all four req held, each with a distinct idx 0..3, op=1. Required: grant order 0,1,2,3,0,... on consecutive cycles; q reaches 8'h0F after 4 grants.
- Test-and-set contention: req1 and req2 both op=1, idx=5, q[5]=0, ptr=1. Required: req1 granted with rd_q=0, then req2 granted the next cycle with rd_q=1; q[5]=1.
- Out of range: NFLAG=6, req0 idx=7, op=1. Required: gnt=4'b0001, err=1, rd_q=0, q unchanged.
- Reset during contention: all reqs high, rst pulsed for 1 cycle after grant to req2. Required: outputs cleared; first post-reset grant goes to req0.
